// File: rtl/r4_input_buf.sv
// r4_input_buf: buffers one N-point complex frame and emits radix-4 DIF groups at stride N/4
module r4_input_buf #(
  parameter int DW = 16,
  parameter int N = 16,
  localparam int GW = (N > 4) ? $clog2(N / 4) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_i,
  input  logic          s_last,
  output logic          g_valid,
  input  logic          g_ready,
  output logic [DW-1:0] g_x0_r,
  output logic [DW-1:0] g_x0_i,
  output logic [DW-1:0] g_x1_r,
  output logic [DW-1:0] g_x1_i,
  output logic [DW-1:0] g_x2_r,
  output logic [DW-1:0] g_x2_i,
  output logic [DW-1:0] g_x3_r,
  output logic [DW-1:0] g_x3_i,
  output logic [GW-1:0] g_idx,
  output logic          g_last,
  output logic          frame_err
);
  localparam int Q = N / 4;
  localparam int AW = $clog2(N);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t          st_q, st_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [GW-1:0]   k_q, k_d, idx_q, idx_d;
  logic            gv_q, gv_d, gl_q, gl_d, err_q, err_d;
  logic [2*DW-1:0] gx_q [4];
  logic [2*DW-1:0] gx_d [4];
  logic [2*DW-1:0] mem_q [4][Q];
  logic            hs, full, load, done;
  logic [1:0]      wbank;
  logic [GW-1:0]   woff;
  assign s_ready = st_q == FILL;
  assign hs = s_valid && s_ready;
  assign full = wcnt_q == AW'(N - 1);
  assign wbank = 2'(wcnt_q / AW'(Q));
  assign woff = GW'(wcnt_q % AW'(Q));
  // the final group must not be reloaded; its handshake ends the drain instead
  assign load = st_q == DRAIN && (!gv_q || (g_ready && !gl_q));
  assign done = gv_q && gl_q && g_ready;
  always_comb begin
    st_d = st_q;
    wcnt_d = wcnt_q;
    k_d = k_q;
    idx_d = idx_q;
    gv_d = gv_q;
    gl_d = gl_q;
    gx_d = gx_q;
    err_d = 1'b0;
    if (hs) begin
      wcnt_d = (s_last || full) ? '0 : wcnt_q + AW'(1);
      err_d = s_last != full;
      st_d = (s_last && full) ? DRAIN : FILL;
      k_d = (s_last && full) ? '0 : k_q;
    end
    if (load) begin
      gv_d = 1'b1;
      idx_d = k_q;
      gl_d = k_q == GW'(Q - 1);
      k_d = k_q + GW'(1);
      gx_d = '{mem_q[0][k_q], mem_q[1][k_q], mem_q[2][k_q], mem_q[3][k_q]};
    end
    if (done) begin
      gv_d = 1'b0;
      gl_d = 1'b0;
      st_d = FILL;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= FILL;
      wcnt_q <= '0;
      k_q <= '0;
      idx_q <= '0;
      gv_q <= 1'b0;
      gl_q <= 1'b0;
      err_q <= 1'b0;
      gx_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      wcnt_q <= wcnt_d;
      k_q <= k_d;
      idx_q <= idx_d;
      gv_q <= gv_d;
      gl_q <= gl_d;
      err_q <= err_d;
      gx_q <= gx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (hs) mem_q[wbank][woff] <= {s_r, s_i};
  end
  assign g_valid = gv_q;
  assign g_idx = idx_q;
  assign g_last = gl_q;
  assign frame_err = err_q;
  assign g_x0_r = gx_q[0][2*DW-1:DW];
  assign g_x0_i = gx_q[0][DW-1:0];
  assign g_x1_r = gx_q[1][2*DW-1:DW];
  assign g_x1_i = gx_q[1][DW-1:0];
  assign g_x2_r = gx_q[2][2*DW-1:DW];
  assign g_x2_i = gx_q[2][DW-1:0];
  assign g_x3_r = gx_q[3][2*DW-1:DW];
  assign g_x3_i = gx_q[3][DW-1:0];
endmodule

// File: tb/tb_r4_input_buf.sv
// tb_r4_input_buf: frame-level scoreboard plus table, directed and random stimulus for r4_input_buf
module tb_r4_input_buf;
  localparam int N = 16, Q = 4;
  typedef struct {logic [127:0] d; logic [1:0] idx; logic last;} grp_t;
  typedef struct {int n; int lp; int base; int sstep; int exp_err; int exp_grp;} vec_t;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, g_ready = 1, gforce = 1, rmode = 0;
  logic [15:0] s_r = 0, s_i = 0;
  logic s_ready, g_valid, g_last, frame_err;
  logic [1:0] g_idx;
  logic [15:0] g_x0_r, g_x0_i, g_x1_r, g_x1_i, g_x2_r, g_x2_i, g_x3_r, g_x3_i;
  logic [127:0] gdat;
  logic [15:0] sr [16];
  logic [15:0] si [16];
  logic [31:0] fr[$];
  grp_t expq[$];
  grp_t g;
  vec_t tv [6];
  logic dead = 0, errp = 0, mready, mgv;
  logic [31:0] g0x0, g3x3;
  int checks = 0, fails = 0, cyc = 0, errcnt = 0, ghcnt = 0, stalls = 0;
  int starts[$];
  int e0, h0, st0;

  r4_input_buf dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i),
    .s_last(s_last), .g_valid(g_valid), .g_ready(g_ready),
    .g_x0_r(g_x0_r), .g_x0_i(g_x0_i), .g_x1_r(g_x1_r), .g_x1_i(g_x1_i),
    .g_x2_r(g_x2_r), .g_x2_i(g_x2_i), .g_x3_r(g_x3_r), .g_x3_i(g_x3_i),
    .g_idx(g_idx), .g_last(g_last), .frame_err(frame_err)
  );

  assign gdat = {g_x0_r, g_x0_i, g_x1_r, g_x1_i, g_x2_r, g_x2_i, g_x3_r, g_x3_i};
  always #5 clk = ~clk;

  task automatic chkb(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    g_ready = rmode ? ($urandom_range(0, 3) != 0) : gforce;
  end

  // scoreboard: collects accepted samples per frame, expects stride-Q groups after one dead cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chkb("rst_g_valid", g_valid, 1'b0);
      chkb("rst_frame_err", frame_err, 1'b0);
      chkb("rst_g_last", g_last, 1'b0);
      chkw("rst_g_x", gdat, '0);
      chkw("rst_g_idx", 128'(g_idx), '0);
      fr.delete();
      expq.delete();
      dead = 0;
      errp = 0;
    end else begin
      mready = expq.size() == 0;
      mgv = !mready && !dead;
      chkb("s_ready", s_ready, mready);
      chkb("frame_err", frame_err, errp);
      chkb("g_valid", g_valid, mgv);
      if (mgv) begin
        chkw("g_x", gdat, expq[0].d);
        chkw("g_idx", 128'(g_idx), 128'(expq[0].idx));
        chkb("g_last", g_last, expq[0].last);
      end
      if (frame_err) errcnt++;
      if (g_valid && !g_ready) stalls++;
      if (g_valid && g_ready) begin
        ghcnt++;
        if (g_idx == 2'd0) g0x0 = gdat[127:96];
        if (g_idx == 2'd3) g3x3 = gdat[31:0];
      end
      errp = 0;
      dead = 0;
      if (mgv && g_ready) void'(expq.pop_front());
      if (s_valid && mready) begin
        if (fr.size() == 0) starts.push_back(cyc);
        fr.push_back({s_r, s_i});
        if (s_last || fr.size() == N) begin
          if (s_last && fr.size() == N) begin
            for (int k = 0; k < Q; k++) begin
              g.d = {fr[k], fr[k+Q], fr[k+2*Q], fr[k+3*Q]};
              g.idx = 2'(k);
              g.last = k == Q - 1;
              expq.push_back(g);
            end
            dead = 1;
          end else errp = 1;
          fr.delete();
        end
      end
    end
  end

  task automatic send(input int n, input int lp, input bit keep, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        s_valid = 0;
        @(posedge clk); #1;
      end
      s_valid = 1;
      s_r = sr[i];
      s_i = si[i];
      s_last = i == lp;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_ready && t < 300);
      if (t >= 300) begin
        fails++;
        $display("FAIL send_timeout sample=%0d", i);
      end
      @(posedge clk); #1;
    end
    if (!keep) begin
      s_valid = 0;
      s_last = 0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq.size() != 0 || dead) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      fails++;
      $display("FAIL idle_timeout pending=%0d", expq.size());
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idx(input logic [1:0] ix);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(g_valid && g_idx == ix) && t < 100);
    if (t >= 100) begin
      fails++;
      $display("FAIL wait_idx_timeout idx=%0d", ix);
    end
  endtask

  task automatic ramp(input int base, input int step);
    for (int i = 0; i < 16; i++) begin
      sr[i] = 16'(base + i);
      si[i] = 16'(step * i);
    end
  endtask

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

  initial begin
    tv[0] = '{16, 15, 1, 0, 0, 4};
    tv[1] = '{3, 2, 50, 3, 1, 0};
    tv[2] = '{16, -1, 60, -5, 1, 0};
    tv[3] = '{16, 15, 101, 0, 0, 4};
    tv[4] = '{1, 0, 7, 1, 1, 0};
    tv[5] = '{16, 15, 200, -9, 0, 4};
    #1;
    chkb("rst_async_g_valid", g_valid, 1'b0);
    chkw("rst_async_g_x", gdat, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chkb("ready_after_release", s_ready, 1'b1);
    @(posedge clk); #1;
    for (int v = 0; v < 6; v++) begin
      e0 = errcnt;
      h0 = ghcnt;
      ramp(tv[v].base, tv[v].sstep);
      send(tv[v].n, tv[v].lp, 0, 0);
      wait_idle();
      chkw($sformatf("vec%0d_err", v), 128'(errcnt - e0), 128'(tv[v].exp_err));
      chkw($sformatf("vec%0d_groups", v), 128'(ghcnt - h0), 128'(tv[v].exp_grp));
    end
    h0 = ghcnt;
    st0 = stalls;
    ramp(1, 0);
    fork
      send(16, 15, 0, 0);
      begin
        wait_idx(2'd0);
        @(posedge clk); #1 gforce = 0;
        repeat (3) @(posedge clk);
        #1 gforce = 1;
      end
    join
    wait_idle();
    chkw("bp_groups", 128'(ghcnt - h0), 128'(4));
    chkw("bp_stall_cycles", 128'(stalls - st0), 128'(3));
    ramp(0, 1);
    sr[0] = 16'h8000; si[0] = 16'h7fff;
    sr[15] = 16'hffff; si[15] = 16'hfffe;
    send(16, 15, 0, 0);
    wait_idle();
    chkw("sign_g0_x0", 128'(g0x0), 128'(32'h8000_7fff));
    chkw("sign_g3_x3", 128'(g3x3), 128'(32'hffff_fffe));
    h0 = ghcnt;
    ramp(300, 2);
    send(16, 15, 1, 0);
    ramp(400, -3);
    send(16, 15, 0, 0);
    wait_idle();
    chkw("b2b_groups", 128'(ghcnt - h0), 128'(8));
    chkw("b2b_period", 128'(starts[starts.size()-1] - starts[starts.size()-2]), 128'(21));
    ramp(500, 1);
    send(16, 15, 0, 0);
    wait_idx(2'd1);
    @(posedge clk); #3 rst = 1;
    #1;
    chkb("midrst_g_valid", g_valid, 1'b0);
    chkw("midrst_g_x", gdat, '0);
    chkw("midrst_g_idx", 128'(g_idx), '0);
    chkb("midrst_s_ready", s_ready, 1'b1);
    @(posedge clk); #1 rst = 0;
    h0 = ghcnt;
    ramp(600, 4);
    send(16, 15, 0, 0);
    wait_idle();
    chkw("postrst_groups", 128'(ghcnt - h0), 128'(4));
    rmode = 1;
    for (int r = 0; r < 40; r++) begin
      int x, n, lp;
      x = $urandom_range(0, 9);
      n = (x < 7 || x == 9) ? 16 : $urandom_range(1, 15);
      lp = (x == 9) ? -1 : n - 1;
      for (int i = 0; i < 16; i++) begin
        sr[i] = 16'($urandom);
        si[i] = 16'($urandom);
      end
      send(n, lp, $urandom_range(0, 1) == 1, 1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    s_valid = 0;
    s_last = 0;
    rmode = 0;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
